// File: rtl/imem_loader.sv
// imem_loader: fills an instruction memory from a byte stream.
// The stream carries a 16-bit big-endian word count, then the program words,
// each sent most-significant byte first. One memory write is issued per word,
// one cycle after the word's last byte is accepted.
//
// Handshake: a byte moves only in a cycle where in_valid and in_ready are both
// high at the rising edge. in_ready depends on the FSM state alone, never on
// in_valid, so the source may hold in_valid/in_data steady while in_ready is low.
module imem_loader #(
   parameter int DEPTH  = 65536,
   parameter int DATA_W = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        dbg_state
);

   // Bytes per word, and a byte-counter width that stays legal when BPW == 1.
   localparam int BPW   = DATA_W / 8;
   localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
   // Width used when comparing the 16-bit header count against word indices
   // and DEPTH; wide enough for both without truncation.
   localparam int CMP_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;

   localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(BPW - 1);
   localparam logic [CMP_W-1:0] DEPTH_C   = CMP_W'(DEPTH);

   // FIN is the cycle carrying the final memory write; it keeps busy high
   // and leads straight to DONE so done rises as the last mem_we drops.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR_HI = 3'd1,
      S_HDR_LO = 3'd2,
      S_LOAD   = 3'd3,
      S_FIN    = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [15:0]       r_count;   // header word count
   logic [BC_W-1:0]   r_byte;    // byte position within the current word
   logic [ADDR_W:0]   r_word;    // index of the word being assembled
   logic [DATA_W-1:0] r_shift;   // word under assembly, shifted in MSB-first
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_in_ready;
   logic              w_busy;
   logic              w_done;
   logic              w_error;
   logic              w_accept;
   logic              w_start_load;
   logic              w_word_end;
   logic              w_last_word;
   logic [15:0]       w_hdr_count;
   logic [CMP_W-1:0]  w_hdr_cmp;
   logic [DATA_W+7:0] w_cat;
   logic [DATA_W-1:0] w_shift_next;

   // The full count as it will be once the low header byte is taken.
   assign w_hdr_count  = {r_count[15:8], in_data};
   assign w_hdr_cmp    = CMP_W'(w_hdr_count);

   // Shift the incoming byte in at the bottom; after BPW bytes the first
   // byte of the word sits in the top byte lane.
   assign w_cat        = {r_shift, in_data};
   assign w_shift_next = w_cat[DATA_W-1:0];

   assign w_accept     = in_valid && w_in_ready;
   assign w_word_end   = w_accept && (r_state == S_LOAD) && (r_byte == BYTE_LAST);
   assign w_last_word  = (CMP_W'(r_word) + CMP_W'(1)) == CMP_W'(r_count);

   // start is honoured only when no load is running; a start during a load is dropped.
   assign w_start_load = start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_error    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_HDR_HI;
            end
         end
         S_HDR_HI: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (in_valid) begin
               w_next = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (in_valid) begin
               if (w_hdr_count == 16'd0) begin
                  w_next = S_DONE;
               end else if (w_hdr_cmp > DEPTH_C) begin
                  w_next = S_ERR;
               end else begin
                  w_next = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (in_valid && (r_byte == BYTE_LAST) && w_last_word) begin
               w_next = S_FIN;
            end
         end
         S_FIN: begin
            w_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (start) begin
               w_next = S_HDR_HI;
            end
         end
         S_ERR: begin
            w_error = 1'b1;
            if (start) begin
               w_next = S_HDR_HI;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Header capture, byte/word counters, word assembly and the write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_byte  <= '0;
         r_word  <= '0;
         r_shift <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_start_load) begin
            r_count <= '0;
            r_byte  <= '0;
            r_word  <= '0;
         end
         if (w_accept && (r_state == S_HDR_HI)) begin
            r_count[15:8] <= in_data;
         end
         if (w_accept && (r_state == S_HDR_LO)) begin
            r_count <= w_hdr_count;
         end
         if (w_accept && (r_state == S_LOAD)) begin
            r_shift <= w_shift_next;
            if (w_word_end) begin
               r_byte  <= '0;
               r_word  <= r_word + 1'b1;
               r_we    <= 1'b1;
               r_addr  <= r_word[ADDR_W-1:0];
               r_wdata <= w_shift_next;
            end else begin
               r_byte <= r_byte + 1'b1;
            end
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign busy      = w_busy;
   assign done      = w_done;
   assign error     = w_error;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (DEPTH=16, DATA_W=32). Drivers stream images and push
// the expected memory writes (address, word, time of appearance) into queues;
// a monitor pops and compares every mem_we it observes.
module tb_imem_loader;

   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int DW     = 32;
   localparam int PERIOD = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW+DW-1:0] exp_q[$];     // {addr, data} of each expected write
   logic [63:0]      exp_t_q[$];   // sim time at which that write is visible
   logic [31:0]      img[$];       // image words for the next load
   logic [63:0]      last_acc_t;

   imem_loader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .dbg_state (dbg_state)
   );

   // Clock generation and watchdog.
   initial begin
      clk = 1'b0;
      forever #(PERIOD / 2) clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every mem_we must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", {32'd0, 28'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("we_addr_data", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
            check("we_time", 64'($time), exp_t_q.pop_front());
         end
      end
   end

   // Present one byte after gap idle cycles; returns once it is accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      last_acc_t = $time;
      #1 in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic fill_random(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
   endtask

   // Stream a header of n words and the words in img. mid_start>0 pulses
   // start after that many accepted bytes; reset_at>0 resets after that many.
   task automatic run_load(input int n, input int max_gap, input int mid_start, input int reset_at);
      logic [15:0] nn;
      logic [31:0] w;
      int nb;
      nn = 16'(n);
      nb = 0;
      pulse_start();
      @(negedge clk);
      check("hdr_ready", {62'd0, in_ready, busy}, 64'h3);
      send_byte(nn[15:8], $urandom_range(0, max_gap));
      send_byte(nn[7:0], $urandom_range(0, max_gap));
      nb = 2;
      if (n == 0) begin
         @(negedge clk);
         check("zero_done", {61'd0, done, busy, in_ready}, 64'h4);
         return;
      end
      if (n > DEPTH) begin
         @(negedge clk);
         check("err_flag", {60'd0, error, done, busy, in_ready}, 64'h8);
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], $urandom_range(0, max_gap));
            nb++;
            if (k == 3) begin
               exp_q.push_back({AW'(i), w});
               exp_t_q.push_back(last_acc_t + 64'(PERIOD / 2));
            end
            if (nb == reset_at) begin
               reset = 1'b1;
               @(posedge clk);
               #1 reset = 1'b0;
               @(negedge clk);
               check("rst_mid_outs", {61'd0, busy, done, in_ready}, 64'h0);
               return;
            end
            if (nb == mid_start) pulse_start();
         end
      end
      @(negedge clk);
      check("final_write_busy", {62'd0, busy, done}, 64'h2);
      @(negedge clk);
      check("load_done", {61'd0, done, busy, in_ready}, 64'h4);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_flags", {59'd0, in_ready, mem_we, busy, done, error}, 64'h0);
      check("rst_addr", 64'(mem_addr), 64'h0);
      check("rst_wdata", 64'(mem_wdata), 64'h0);
      reset = 1'b0;

      // start together with reset: reset wins
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_beats_start", {62'd0, busy, in_ready}, 64'h0);

      // fixed two-word image
      img.delete();
      img.push_back(32'h8A00_0001);
      img.push_back(32'h01C0_0005);
      run_load(2, 0, 0, 0);

      // empty image
      run_load(0, 0, 0, 0);

      // image one word larger than memory; later bytes not accepted
      run_load(DEPTH + 1, 0, 0, 0);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("err_no_ready", {62'd0, in_ready, error}, 64'h1);
      end
      in_valid = 1'b0;

      // random gaps
      fill_random(3);
      run_load(3, 5, 0, 0);

      // exactly DEPTH words is legal
      fill_random(DEPTH);
      run_load(DEPTH, 1, 0, 0);

      // reset after 6 bytes, then a full reload
      fill_random(3);
      run_load(3, 2, 0, 6);
      check("rst_queue_drained", 64'(exp_q.size()), 64'd0);
      fill_random(3);
      run_load(3, 2, 0, 0);

      // start pulsed mid-load is ignored
      fill_random(3);
      run_load(3, 1, 7, 0);
      pulse_start();
      @(negedge clk);
      check("start_clears_done", {62'd0, done, busy}, 64'h1);
      // that start already began a load: finish it as a one-word image
      img.delete();
      img.push_back($urandom);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      for (int k = 0; k < 4; k++) send_byte(img[0][31-8*k -: 8], 0);
      exp_q.push_back({AW'(0), img[0]});
      exp_t_q.push_back(last_acc_t + 64'(PERIOD / 2));
      @(negedge clk);
      @(negedge clk);
      check("one_word_done", {62'd0, done, busy}, 64'h2);

      // a few random loads
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, DEPTH);
         fill_random(n);
         run_load(n, 3, 0, 0);
      end

      repeat (3) @(negedge clk);
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
